// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response codes and channel FSM state types for axi_ram_slave
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } axi_ram_wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } axi_ram_rd_state_e;

endpackage

// File: rtl/axi_ram_mem.sv
// rtl/axi_ram_mem.sv - word RAM, byte-enable write port, read-first sync read port
// Optional per-word user column when AXI_RAM_USER_STORE_EN is defined.
module axi_ram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_AW     = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [MEM_AW-1:0]       waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [USER_WIDTH-1:0]   wuser,
    input  logic                    re,
    input  logic [MEM_AW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [USER_WIDTH-1:0]   ruser
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Nonblocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef AXI_RAM_USER_STORE_EN
    logic [USER_WIDTH-1:0] umem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && |wstrb) begin
            umem[waddr] <= wuser;
        end
        if (re) begin
            ruser <= umem[raddr];
        end
    end
`else
    logic unused_wuser;
    assign unused_wuser = ^wuser;
    assign ruser        = '0;
`endif

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI INCR-burst slave RAM with independent write/read FSMs
// Optional user-bit storage enabled by AXI_RAM_USER_STORE_EN.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MEM_DEPTH  = 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [USER_WIDTH-1:0]   wuser,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic [USER_WIDTH-1:0]   buser,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic [USER_WIDTH-1:0]   ruser,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(BYTES);
    localparam int WORD_W = ADDR_WIDTH - OFFS;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WORD_W:0]       DEPTH_L   = (WORD_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a[ADDR_WIDTH-1:OFFS]} < DEPTH_L;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return MEM_AW'(a[ADDR_WIDTH-1:OFFS]);
    endfunction

    // Holds address-channel ready low until the first edge after reset release.
    logic hs_en;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) hs_en <= 1'b0;
        else          hs_en <= 1'b1;
    end

    logic [USER_WIDTH-1:0] wuser_eff;
`ifdef AXI_RAM_USER_STORE_EN
    assign wuser_eff = wuser;
`else
    logic unused_wuser;
    assign unused_wuser = ^wuser;
    assign wuser_eff    = '0;
`endif

    axi_ram_wr_state_e     wr_state, wr_state_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [7:0]            wr_len, wr_len_nxt;
    logic [8:0]            wr_cnt, wr_cnt_nxt;
    logic                  wr_err, wr_err_nxt;
    logic [USER_WIDTH-1:0] buser_q, buser_nxt;
    logic                  mem_we;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
            buser_q  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_len   <= wr_len_nxt;
            wr_cnt   <= wr_cnt_nxt;
            wr_err   <= wr_err_nxt;
            buser_q  <= buser_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_addr_nxt  = wr_addr;
        wr_len_nxt   = wr_len;
        wr_cnt_nxt   = wr_cnt;
        wr_err_nxt   = wr_err;
        buser_nxt    = buser_q;
        awready      = 1'b0;
        wready       = 1'b0;
        mem_we       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                awready = hs_en;
                if (awvalid && hs_en) begin
                    wr_addr_nxt  = awaddr;
                    wr_len_nxt   = awlen;
                    wr_cnt_nxt   = '0;
                    wr_err_nxt   = 1'b0;
                    wr_state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    wr_addr_nxt = wr_addr + ADDR_STEP;
                    // wr_cnt saturates one past the last legal beat; extra beats are dropped
                    if (wr_cnt > {1'b0, wr_len}) begin
                        wr_err_nxt = 1'b1;
                    end else begin
                        wr_cnt_nxt = wr_cnt + 9'd1;
                        if (in_range(wr_addr)) mem_we     = 1'b1;
                        else                   wr_err_nxt = 1'b1;
                    end
                    if (wlast) begin
                        if (wr_cnt != {1'b0, wr_len}) wr_err_nxt = 1'b1;
                        buser_nxt    = wuser_eff;
                        wr_state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    assign bvalid = (wr_state == WR_RESP);
    assign bresp  = (bvalid && wr_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign buser  = bvalid ? buser_q : '0;

    axi_ram_rd_state_e     rd_state, rd_state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
    logic [7:0]            rd_len, rd_len_nxt;
    logic [7:0]            rd_cnt, rd_cnt_nxt;
    logic                  rd_oor, rd_oor_nxt;
    logic                  mem_re;
    logic [MEM_AW-1:0]     mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [USER_WIDTH-1:0] mem_ruser;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_oor   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_addr  <= rd_addr_nxt;
            rd_len   <= rd_len_nxt;
            rd_cnt   <= rd_cnt_nxt;
            rd_oor   <= rd_oor_nxt;
        end
    end

    // rd_addr always points at the beat to be prefetched on the next handshake.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_addr_nxt  = rd_addr;
        rd_len_nxt   = rd_len;
        rd_cnt_nxt   = rd_cnt;
        rd_oor_nxt   = rd_oor;
        arready      = 1'b0;
        mem_re       = 1'b0;
        mem_raddr    = word_idx(rd_addr);
        case (rd_state)
            RD_IDLE: begin
                arready = hs_en;
                if (arvalid && hs_en) begin
                    mem_re       = 1'b1;
                    mem_raddr    = word_idx(araddr);
                    rd_oor_nxt   = !in_range(araddr);
                    rd_addr_nxt  = araddr + ADDR_STEP;
                    rd_len_nxt   = arlen;
                    rd_cnt_nxt   = '0;
                    rd_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (rd_cnt == rd_len) begin
                        rd_state_nxt = RD_IDLE;
                    end else begin
                        mem_re      = 1'b1;
                        rd_oor_nxt  = !in_range(rd_addr);
                        rd_addr_nxt = rd_addr + ADDR_STEP;
                        rd_cnt_nxt  = rd_cnt + 8'd1;
                    end
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    assign rvalid = (rd_state == RD_DATA);
    assign rlast  = rvalid && (rd_cnt == rd_len);
    assign rdata  = (rvalid && !rd_oor) ? mem_rdata : '0;
    assign rresp  = (rvalid && rd_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign ruser  = (rvalid && !rd_oor) ? mem_ruser : '0;

    axi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_AW     (MEM_AW)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (word_idx(wr_addr)),
        .wstrb (wstrb),
        .wdata (wdata),
        .wuser (wuser_eff),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .ruser (mem_ruser)
    );

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - randomized bench for axi_ram_slave against an array reference model
`timescale 1ns/1ps
module tb_axi_ram_slave;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int UW    = 1;
    localparam int DEPTH = 128;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic [UW-1:0] wuser = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic [UW-1:0] buser;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic [UW-1:0] ruser;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_ram_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .aclk (aclk), .aresetn (aresetn),
        .awaddr (awaddr), .awlen (awlen), .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wuser (wuser), .wlast (wlast),
        .wvalid (wvalid), .wready (wready),
        .bresp (bresp), .buser (buser), .bvalid (bvalid), .bready (bready),
        .araddr (araddr), .arlen (arlen), .arvalid (arvalid), .arready (arready),
        .rdata (rdata), .rresp (rresp), .ruser (ruser), .rlast (rlast),
        .rvalid (rvalid), .rready (rready)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem  [DEPTH];
    logic        ref_user [DEPTH];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic        wq_user [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic queue_beat(input logic [31:0] d, input logic [3:0] s, input logic u);
        wq_data.push_back(d);
        wq_strb.push_back(s);
        wq_user.push_back(u);
    endtask

    // Applies the queued W beats as one burst; the model is updated from the burst rules.
    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input int gap_pct);
        int          nb;
        int          t;
        int          w;
        logic [AW-1:0] a;
        logic        err;
        logic        exp_user;
        nb  = wq_data.size();
        err = 1'b0;
        for (int i = 0; i < nb; i++) begin
            a = addr + AW'(4 * i);
            w = int'(a[AW-1:2]);
            if (i > int'(len)) begin
                err = 1'b1;
            end else if (w >= DEPTH) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wq_strb[i][b]) ref_mem[w][8*b +: 8] = wq_data[i][8*b +: 8];
                if (wq_strb[i] != 4'h0) ref_user[w] = wq_user[i];
            end
        end
        if (nb != int'(len) + 1) err = 1'b1;
`ifdef AXI_RAM_USER_STORE_EN
        exp_user = wq_user[nb-1];
`else
        exp_user = 1'b0;
`endif
        @(negedge aclk);
        awaddr = addr; awlen = len; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        chk("awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            while ($urandom_range(99) < gap_pct) @(negedge aclk);
            wvalid = 1'b1; wdata = wq_data[i]; wstrb = wq_strb[i];
            wuser = wq_user[i]; wlast = (i == nb - 1);
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            chk("wready", wready, 1);
            @(negedge aclk);
            wvalid = 1'b0; wlast = 1'b0;
        end
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        chk("buser", buser, exp_user);
        repeat ($urandom_range(2)) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_clr", bvalid, 0);
        wq_data.delete(); wq_strb.delete(); wq_user.delete();
    endtask

    // rready follows pat for the first 32 cycles, then is random.
    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] pat);
        int            t;
        int            k;
        int            beat;
        int            w;
        logic [AW-1:0] a;
        logic          rr;
        logic          stalled;
        logic [31:0]   hd;
        logic [1:0]    hr;
        logic          hl;
        logic          hu;
        logic [31:0]   ed;
        logic [1:0]    er;
        logic          eu;
        @(negedge aclk);
        araddr = addr; arlen = len; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        chk("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        t = 0; k = 0; beat = 0; stalled = 1'b0;
        hd = '0; hr = '0; hl = 1'b0; hu = 1'b0;
        while (beat <= int'(len) && t < 2000) begin
            rr = (k < 32) ? pat[k] : ($urandom_range(3) != 0);
            k++;
            if (stalled) begin
                chk("rvalid_hold", rvalid, 1);
                chk("rdata_stable", rdata, hd);
                chk("rresp_stable", rresp, hr);
                chk("rlast_stable", rlast, hl);
                chk("ruser_stable", ruser, hu);
            end
            if (rvalid) begin
                if (rr) begin
                    a = addr + AW'(4 * beat);
                    w = int'(a[AW-1:2]);
                    if (w >= DEPTH) begin
                        ed = '0; er = 2'b10; eu = 1'b0;
                    end else begin
                        ed = ref_mem[w]; er = 2'b00;
`ifdef AXI_RAM_USER_STORE_EN
                        eu = ref_user[w];
`else
                        eu = 1'b0;
`endif
                    end
                    chk("rdata", rdata, ed);
                    chk("rresp", rresp, er);
                    chk("rlast", rlast, beat == int'(len));
                    chk("ruser", ruser, eu);
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = rdata; hr = rresp; hl = rlast; hu = ruser;
                end
            end
            rready = rr;
            @(negedge aclk);
            t++;
        end
        rready = 1'b0;
        chk("rbeats", beat, int'(len) + 1);
        chk("rvalid_end", rvalid, 0);
    endtask

    initial begin
        logic [31:0]   old_d;
        logic [31:0]   new_d;
        logic [AW-1:0] ra;
        logic [7:0]    rl;
        int            nb;
        int            t;

        repeat (3) @(negedge aclk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_buser", buser, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ruser", ruser, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < DEPTH; i++) queue_beat($urandom(), 4'hF, 1'($urandom_range(1)));
        do_write(10'h000, 8'd127, 0);
        do_read(10'h000, 8'd127, $urandom());

        for (int i = 0; i < 4; i++) queue_beat(32'hA0 + 32'(i), 4'hF, 1'b0);
        do_write(10'h010, 8'd3, 0);
        do_read(10'h010, 8'd3, 32'hFFFF_FFFF);

        queue_beat(32'hFFFF_FFFF, 4'hF, 1'b0);
        do_write(10'h040, 8'd0, 0);
        queue_beat(32'h0000_0012, 4'b0001, 1'b0);
        do_write(10'h040, 8'd0, 0);
        do_read(10'h040, 8'd0, 32'hFFFF_FFFF);
        chk("strb_merge_model", ref_mem[16], 32'hFFFF_FF12);

        do_read(10'h1F8, 8'd3, 32'hFFFF_FFFF);

        for (int i = 0; i < 2; i++) queue_beat($urandom(), 4'hF, 1'b0);
        do_write(10'h060, 8'd3, 0);
        do_read(10'h060, 8'd3, 32'hFFFF_FFFF);

        for (int i = 0; i < 4; i++) queue_beat($urandom(), 4'hF, 1'b0);
        do_write(10'h070, 8'd1, 20);
        do_read(10'h070, 8'd3, 32'hFFFF_FFFF);

        for (int i = 0; i < 2; i++) queue_beat($urandom(), 4'hF, 1'b1);
        do_write(10'h1FC, 8'd1, 0);
        do_read(10'h1FC, 8'd1, 32'hFFFF_FFFF);

        do_read(10'h020, 8'd7, 32'hFFFF_FFF9);
        do_read(10'h3F8, 8'd3, 32'hFFFF_FFFF);

        queue_beat($urandom(), 4'hF, 1'b1);
        do_write(10'h0A0, 8'd0, 0);
        do_read(10'h0A0, 8'd0, 32'hFFFF_FFFF);

        for (int it = 0; it < 40; it++) begin
            ra = AW'($urandom());
            rl = 8'($urandom_range(15));
            nb = int'(rl) + 1;
            if ($urandom_range(4) == 0) nb = 1 + $urandom_range(int'(rl) + 2);
            for (int i = 0; i < nb; i++)
                queue_beat($urandom(), 4'($urandom()), 1'($urandom_range(1)));
            do_write(ra, rl, 30);
            do_read(AW'($urandom()), 8'($urandom_range(15)), $urandom());
            do_read(ra, rl, $urandom());
        end

        // Same-edge write and read of word 0x20: the read must see the old contents.
        old_d = ref_mem[32];
        new_d = ~old_d;
        @(negedge aclk);
        awaddr = 10'h080; awlen = 8'd0; awvalid = 1'b1;
        chk("rf_awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = new_d; wstrb = 4'hF; wuser = 1'b1; wlast = 1'b1;
        arvalid = 1'b1; araddr = 10'h080; arlen = 8'd0;
        chk("rf_wready", wready, 1);
        chk("rf_arready", arready, 1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk("rf_rvalid", rvalid, 1);
        chk("rf_old_data", rdata, old_d);
        chk("rf_bvalid", bvalid, 1);
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        ref_mem[32]  = new_d;
        ref_user[32] = 1'b1;
        do_read(10'h080, 8'd0, 32'hFFFF_FFFF);

        // Reset while beat 2 of a 4-beat burst is being offered.
        @(negedge aclk);
        awaddr = 10'h100; awlen = 8'd3; awvalid = 1'b1;
        chk("mr_awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            new_d = $urandom();
            wvalid = 1'b1; wdata = new_d; wstrb = 4'hF; wuser = 1'b0; wlast = 1'b0;
            chk("mr_wready", wready, 1);
            ref_mem[64 + i] = new_d;
            ref_user[64 + i] = 1'b0;
            @(negedge aclk);
        end
        wdata = $urandom();
        aresetn = 1'b0;
        #1;
        chk("mr_rst_wready", wready, 0);
        chk("mr_rst_awready", awready, 0);
        @(negedge aclk);
        wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        t = 0;
        repeat (4) begin
            @(negedge aclk);
            if (bvalid) t++;
        end
        chk("mr_no_bvalid", t, 0);
        chk("mr_awready_back", awready, 1);
        do_read(10'h100, 8'd3, $urandom());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
